// File: rtl/pe2ddr_pack_if.sv
// DDR write-channel stream between pe2ddr_pack and the DDR writer.
// Signals:
//   ddr2_data   output word, lane i at [i*RES_W +: RES_W]
//   ddr2_valid  word valid
//   ddr2_ready  sink ready; a word transfers when valid & ready
// Modports: master (packer side), slave (sink side).
interface pe2ddr_pack_if #(
  parameter int unsigned DDR_W = 512
);
  logic [DDR_W-1:0] ddr2_data;
  logic             ddr2_valid;
  logic             ddr2_ready;

  modport master (output ddr2_data, output ddr2_valid, input ddr2_ready);
  modport slave  (input ddr2_data, input ddr2_valid, output ddr2_ready);
endinterface

// File: rtl/pe2ddr_pack.sv
// pe2ddr_pack: drains the PE accumulator buffer (abuf) or bias buffer (bbuf) into DDR_W words
// on a valid/ready stream through a small first-word-fall-through output FIFO.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start/done/busy        job control: start pulse, one-cycle done pulse, busy while running
//   conf_mode              00 group sum, 01 group select, 10 bbuf data pack, 11 bbuf tail pack
//   conf_grp_sel           group index for mode 01
//   conf_base_addr         first buffer address (wraps at BUF_DEPTH)
//   conf_trans_num         number of output words (0 = none)
//   abuf_rd_* / bbuf_rd_*  buffer read ports, data valid the cycle after rd_en
//   ddr2                   output stream (pe2ddr_pack_if master)
// Build option: define PE2DDR_SAT_EN to saturate mode 00 sums instead of wrapping.
module pe2ddr_pack #(
  parameter int unsigned BATCH       = 16,
  parameter int unsigned GRP_NUM     = 4,
  parameter int unsigned RES_W       = 32,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TAIL_W      = 16,
  parameter int unsigned DDR_W       = 512,
  parameter int unsigned BUF_DEPTH   = 256,
  parameter int unsigned ADDR_W      = $clog2(BUF_DEPTH),
  parameter int unsigned OFIFO_DEPTH = 4,
  parameter int unsigned GSEL_W      = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           done,
  output logic                           busy,
  input  logic [1:0]                     conf_mode,
  input  logic [GSEL_W-1:0]              conf_grp_sel,
  input  logic [ADDR_W-1:0]              conf_base_addr,
  input  logic [7:0]                     conf_trans_num,
  output logic [ADDR_W-1:0]              abuf_rd_addr,
  output logic                           abuf_rd_en,
  input  logic [GRP_NUM*BATCH*RES_W-1:0] abuf_rd_data,
  output logic [ADDR_W-1:0]              bbuf_rd_addr,
  output logic                           bbuf_rd_en,
  input  logic [RES_W-1:0]               bbuf_rd_data,
  pe2ddr_pack_if.master                  ddr2
);

  localparam int unsigned DPACK    = DDR_W / DATA_W;
  localparam int unsigned TPACK    = DDR_W / TAIL_W;
  localparam int unsigned PACK_MAX = (DPACK > TPACK) ? DPACK : TPACK;
  localparam int unsigned SUB_W    = (PACK_MAX > 1) ? $clog2(PACK_MAX) : 1;
  localparam int unsigned CNT_W    = $clog2(OFIFO_DEPTH + 1);
  localparam int unsigned PTR_W    = $clog2(OFIFO_DEPTH);
`ifdef PE2DDR_SAT_EN
  localparam int unsigned ACC_W    = RES_W + $clog2(GRP_NUM) + 1;
`else
  localparam int unsigned ACC_W    = RES_W;
`endif

  localparam logic [CNT_W-1:0]  DepthC   = CNT_W'(OFIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PtrLast  = PTR_W'(OFIFO_DEPTH - 1);
  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
  state_e state_q, state_d;

  logic [1:0]        mode_q;
  logic [GSEL_W-1:0] grp_q;
  logic [7:0]        trans_q, wcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [SUB_W-1:0]  sub_q, pack_last;
  logic [CNT_W-1:0]  cred_q, cred_d;

  logic              rd_vld_q, rd_last_q;
  logic [SUB_W-1:0]  rd_lane_q;
  logic [DDR_W-1:0]  pack_q, pack_nxt, red_q, red_word;
  logic              red_vld_q;

  logic [DDR_W-1:0]  fifo_mem [OFIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  fcnt_q;

  logic issue, word_last, new_word, final_read, push, pop;

  // Credits cover every word from its first read until it leaves the FIFO, so the issue
  // decision never looks at ddr2_ready. Reads inside a started bbuf word always proceed.
  assign pack_last  = mode_q[0] ? SUB_W'(TPACK - 1) : SUB_W'(DPACK - 1);
  assign issue      = (state_q == StRun) && ((sub_q != '0) || (cred_q < DepthC));
  assign word_last  = !mode_q[1] || (sub_q == pack_last);
  assign new_word   = issue && (sub_q == '0);
  assign final_read = issue && word_last && (wcnt_q == trans_q - 8'd1);
  assign push       = red_vld_q;
  assign pop        = ddr2.ddr2_valid && ddr2.ddr2_ready;
  assign cred_d     = cred_q + CNT_W'(new_word) - CNT_W'(pop);

  assign abuf_rd_en   = issue && !mode_q[1];
  assign bbuf_rd_en   = issue && mode_q[1];
  assign abuf_rd_addr = addr_q;
  assign bbuf_rd_addr = addr_q;

  assign done = (state_q == StDone);
  assign busy = (state_q == StRun) || (state_q == StDrain);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = (conf_trans_num == 8'd0) ? StDone : StRun;
      StRun:   if (final_read) state_d = StDrain;
      StDrain: if (cred_d == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= '0;
      grp_q   <= '0;
      trans_q <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      sub_q   <= '0;
      cred_q  <= '0;
    end else begin
      state_q <= state_d;
      cred_q  <= cred_d;
      if (state_q == StIdle && start) begin
        mode_q  <= conf_mode;
        grp_q   <= conf_grp_sel;
        trans_q <= conf_trans_num;
        addr_q  <= conf_base_addr;
        wcnt_q  <= '0;
        sub_q   <= '0;
      end else if (issue) begin
        addr_q <= (addr_q == AddrLast) ? '0 : addr_q + ADDR_W'(1);
        if (word_last) begin
          sub_q  <= '0;
          wcnt_q <= wcnt_q + 8'd1;
        end else begin
          sub_q <= sub_q + SUB_W'(1);
        end
      end
    end
  end

  // Reduction / packing of the word whose read data is on the buffer outputs this cycle.
  logic [ACC_W-1:0] acc;
  logic [RES_W-1:0] lane, sel, sum;
  always_comb begin
    red_word = '0;
    pack_nxt = pack_q;
    acc      = '0;
    lane     = '0;
    sel      = '0;
    sum      = '0;
    for (int i = 0; i < BATCH; i++) begin
      acc = '0;
      sel = '0;
      for (int g = 0; g < GRP_NUM; g++) begin
        lane = abuf_rd_data[(g*BATCH+i)*RES_W +: RES_W];
`ifdef PE2DDR_SAT_EN
        acc = acc + {{(ACC_W-RES_W){lane[RES_W-1]}}, lane};
`else
        acc = acc + lane;
`endif
        if (grp_q == GSEL_W'(g)) sel = lane;
      end
`ifdef PE2DDR_SAT_EN
      // In range iff every bit above the result sign matches it.
      if ((&acc[ACC_W-1:RES_W-1]) || !(|acc[ACC_W-1:RES_W-1])) sum = acc[RES_W-1:0];
      else if (acc[ACC_W-1]) sum = {1'b1, {(RES_W-1){1'b0}}};
      else sum = {1'b0, {(RES_W-1){1'b1}}};
`else
      sum = acc;
`endif
      red_word[i*RES_W +: RES_W] = mode_q[0] ? sel : sum;
    end
    for (int k = 0; k < DPACK; k++) begin
      if (!mode_q[0] && rd_lane_q == SUB_W'(k))
        pack_nxt[k*DATA_W +: DATA_W] = bbuf_rd_data[RES_W-1 -: DATA_W];
    end
    for (int k = 0; k < TPACK; k++) begin
      if (mode_q[0] && rd_lane_q == SUB_W'(k))
        pack_nxt[k*TAIL_W +: TAIL_W] = bbuf_rd_data[TAIL_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      rd_lane_q <= '0;
      pack_q    <= '0;
      red_q     <= '0;
      red_vld_q <= 1'b0;
    end else begin
      rd_vld_q  <= issue;
      rd_last_q <= word_last;
      rd_lane_q <= sub_q;
      red_vld_q <= rd_vld_q && rd_last_q;
      if (rd_vld_q) begin
        pack_q <= pack_nxt;
        red_q  <= mode_q[1] ? pack_nxt : red_word;
      end
    end
  end

  // Output FIFO; credits guarantee it never overflows.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= red_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == PtrLast) ? '0 : wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= (rptr_q == PtrLast) ? '0 : rptr_q + PTR_W'(1);
      fcnt_q <= fcnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign ddr2.ddr2_valid = (fcnt_q != '0);
  assign ddr2.ddr2_data  = ddr2.ddr2_valid ? fifo_mem[rptr_q] : '0;

endmodule

// File: tb/tb_pe2ddr_pack.sv
module tb_pe2ddr_pack;
  localparam int unsigned BATCH = 16, GRP_NUM = 4, RES_W = 32, DATA_W = 16, TAIL_W = 16;
  localparam int unsigned DDR_W = 512, BUF_DEPTH = 256, ADDR_W = 8, OFIFO_DEPTH = 4;
  localparam int unsigned AW = GRP_NUM * BATCH * RES_W;

  logic              clk = 1'b0;
  logic              rst_n, start, done, busy;
  logic [1:0]        conf_mode, conf_grp_sel;
  logic [ADDR_W-1:0] conf_base_addr, abuf_rd_addr, bbuf_rd_addr;
  logic [7:0]        conf_trans_num;
  logic              abuf_rd_en, bbuf_rd_en;
  logic [AW-1:0]     abuf_rd_data;
  logic [RES_W-1:0]  bbuf_rd_data;

  logic [AW-1:0]     abuf_mem [BUF_DEPTH];
  logic [RES_W-1:0]  bbuf_mem [BUF_DEPTH];

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  pe2ddr_pack_if #(.DDR_W(DDR_W)) ddr2_if ();

  pe2ddr_pack #(
    .BATCH(BATCH), .GRP_NUM(GRP_NUM), .RES_W(RES_W), .DATA_W(DATA_W), .TAIL_W(TAIL_W),
    .DDR_W(DDR_W), .BUF_DEPTH(BUF_DEPTH), .ADDR_W(ADDR_W), .OFIFO_DEPTH(OFIFO_DEPTH)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .busy(busy),
    .conf_mode(conf_mode), .conf_grp_sel(conf_grp_sel), .conf_base_addr(conf_base_addr),
    .conf_trans_num(conf_trans_num),
    .abuf_rd_addr(abuf_rd_addr), .abuf_rd_en(abuf_rd_en), .abuf_rd_data(abuf_rd_data),
    .bbuf_rd_addr(bbuf_rd_addr), .bbuf_rd_en(bbuf_rd_en), .bbuf_rd_data(bbuf_rd_data),
    .ddr2(ddr2_if)
  );

  // Synchronous-read buffer models
  always @(posedge clk) begin
    if (abuf_rd_en) abuf_rd_data <= abuf_mem[abuf_rd_addr];
    if (bbuf_rd_en) bbuf_rd_data <= bbuf_mem[bbuf_rd_addr];
  end

  task automatic check_eq(input string tag, input logic [DDR_W-1:0] got,
                          input logic [DDR_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor, sampled on the falling edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DDR_W-1:0] got_q [$];
  int               rd_addr_q [$];
  int               rd_cnt, first_valid, done_cyc, hs_last, start_cyc;
  logic             stall_prev = 1'b0;
  logic [DDR_W-1:0] stall_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_valid_hold", DDR_W'(ddr2_if.ddr2_valid), DDR_W'(1));
        check_eq("stall_data_hold", ddr2_if.ddr2_data, stall_data);
      end
      stall_prev = ddr2_if.ddr2_valid && !ddr2_if.ddr2_ready;
      stall_data = ddr2_if.ddr2_data;
      if (ddr2_if.ddr2_valid && ddr2_if.ddr2_ready) begin
        got_q.push_back(ddr2_if.ddr2_data);
        hs_last = cyc;
      end
      if (ddr2_if.ddr2_valid && first_valid < 0) first_valid = cyc;
      if (abuf_rd_en) begin rd_cnt++; rd_addr_q.push_back(int'(abuf_rd_addr)); end
      if (bbuf_rd_en) begin rd_cnt++; rd_addr_q.push_back(int'(bbuf_rd_addr)); end
      if (done) done_cyc = cyc;
      if (start && start_cyc < 0) start_cyc = cyc;
    end
  end

  function automatic logic [DDR_W-1:0] splat(input logic [RES_W-1:0] v);
    logic [DDR_W-1:0] w;
    for (int i = 0; i < BATCH; i++) w[i*RES_W +: RES_W] = v;
    return w;
  endfunction

  task automatic set_lane(input int a, input int g, input int i, input logic [RES_W-1:0] v);
    abuf_mem[a][(g*BATCH+i)*RES_W +: RES_W] = v;
  endtask

  task automatic do_start(input logic [1:0] mode, input logic [1:0] grp,
                          input logic [7:0] base, input logic [7:0] num);
    got_q.delete();
    rd_addr_q.delete();
    rd_cnt = 0; first_valid = -1; done_cyc = -1; hs_last = -1; start_cyc = -1;
    @(posedge clk); #1;
    conf_mode = mode; conf_grp_sel = grp; conf_base_addr = base; conf_trans_num = num;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // pat 0: ready held high, 1: ready toggles every cycle
  task automatic wait_done(input int pat, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      ddr2_if.ddr2_ready = (pat == 0) ? 1'b1 : ((n % 2) == 0);
      @(posedge clk); #1;
      n++;
    end
    check_eq("done_within_budget", DDR_W'(done), DDR_W'(1));
    @(negedge clk); #1;
  endtask

  logic [DDR_W-1:0] exp_w;
  int               a;

  initial begin
    rst_n = 1'b0; start = 1'b0; conf_mode = '0; conf_grp_sel = '0;
    conf_base_addr = '0; conf_trans_num = '0; ddr2_if.ddr2_ready = 1'b1;
    abuf_rd_data = '0; bbuf_rd_data = '0;
    for (int k = 0; k < int'(BUF_DEPTH); k++) begin
      abuf_mem[k] = '0;
      bbuf_mem[k] = {k[15:0], 16'hFFFF};
    end
    #1;
    check_eq("rst_valid", DDR_W'(ddr2_if.ddr2_valid), '0);
    check_eq("rst_data", ddr2_if.ddr2_data, '0);
    check_eq("rst_busy_done", DDR_W'({busy, done}), '0);
    check_eq("rst_rd_en", DDR_W'({abuf_rd_en, bbuf_rd_en}), '0);
    check_eq("rst_addr", DDR_W'({abuf_rd_addr, bbuf_rd_addr}), '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Group sum: lanes 1+2+3+4 = 10
    for (int ad = 10; ad < 13; ad++)
      for (int g = 0; g < 4; g++)
        for (int i = 0; i < 16; i++) set_lane(ad, g, i, RES_W'(g + 1));
    ddr2_if.ddr2_ready = 1'b1;
    do_start(2'b00, 2'd0, 8'd10, 8'd3);
    wait_done(0, 200);
    check_eq("sum_count", DDR_W'(got_q.size()), DDR_W'(3));
    for (int w = 0; w < 3; w++)
      if (got_q.size() > w) check_eq("sum_word", got_q[w], splat(32'd10));
    check_eq("sum_rd_cnt", DDR_W'(rd_cnt), DDR_W'(3));
    for (int w = 0; w < 3; w++)
      if (rd_addr_q.size() > w) check_eq("sum_rd_addr", DDR_W'(rd_addr_q[w]), DDR_W'(10 + w));
    check_eq("sum_latency", DDR_W'(first_valid - start_cyc), DDR_W'(4));
    check_eq("sum_done_timing", DDR_W'(done_cyc - hs_last), DDR_W'(1));

    // Group select, ready toggling
    for (int w = 0; w < 2; w++)
      for (int g = 0; g < 4; g++)
        for (int i = 0; i < 16; i++)
          set_lane(20 + w, g, i, (g == 2) ? RES_W'(i + 100 * w) : (32'hDEAD0000 + RES_W'(g)));
    do_start(2'b01, 2'd2, 8'd20, 8'd2);
    wait_done(1, 200);
    check_eq("sel_count", DDR_W'(got_q.size()), DDR_W'(2));
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 16; i++) exp_w[i*RES_W +: RES_W] = RES_W'(i + 100 * w);
      if (got_q.size() > w) check_eq("sel_word", got_q[w], exp_w);
    end

    // bbuf data pack, then tail pack
    do_start(2'b10, 2'd0, 8'd0, 8'd1);
    wait_done(0, 300);
    for (int k = 0; k < 32; k++) exp_w[k*DATA_W +: DATA_W] = DATA_W'(k);
    check_eq("dpack_count", DDR_W'(got_q.size()), DDR_W'(1));
    if (got_q.size() > 0) check_eq("dpack_word", got_q[0], exp_w);
    check_eq("dpack_rd_cnt", DDR_W'(rd_cnt), DDR_W'(32));
    do_start(2'b11, 2'd0, 8'd0, 8'd1);
    wait_done(0, 300);
    check_eq("tpack_count", DDR_W'(got_q.size()), DDR_W'(1));
    if (got_q.size() > 0) check_eq("tpack_word", got_q[0], '1);

    // Backpressure with address wrap 254 -> 0
    for (int w = 0; w < 8; w++) begin
      a = (254 + w) % 256;
      for (int g = 0; g < 4; g++)
        for (int i = 0; i < 16; i++) set_lane(a, g, i, RES_W'(a * 16 + i + g));
    end
    ddr2_if.ddr2_ready = 1'b0;
    do_start(2'b00, 2'd0, 8'd254, 8'd8);
    repeat (20) @(posedge clk);
    #1;
    check_eq("bp_reads_stalled", DDR_W'(rd_cnt), DDR_W'(OFIFO_DEPTH));
    wait_done(0, 300);
    check_eq("bp_count", DDR_W'(got_q.size()), DDR_W'(8));
    for (int w = 0; w < 8; w++) begin
      a = (254 + w) % 256;
      for (int i = 0; i < 16; i++) exp_w[i*RES_W +: RES_W] = RES_W'(4 * (a * 16 + i) + 6);
      if (got_q.size() > w) check_eq("bp_word", got_q[w], exp_w);
      if (rd_addr_q.size() > w) check_eq("bp_rd_addr", DDR_W'(rd_addr_q[w]), DDR_W'(a));
    end

    // Zero-length job
    do_start(2'b00, 2'd0, 8'd0, 8'd0);
    wait_done(0, 20);
    check_eq("zero_done_timing", DDR_W'(done_cyc - start_cyc), DDR_W'(1));
    check_eq("zero_no_valid", DDR_W'(first_valid), DDR_W'(-1));

    // start while busy is ignored
    for (int ad = 40; ad < 42; ad++)
      for (int g = 0; g < 4; g++)
        for (int i = 0; i < 16; i++) set_lane(ad, g, i, RES_W'(5 * (g + 1)));
    ddr2_if.ddr2_ready = 1'b1;
    do_start(2'b00, 2'd0, 8'd40, 8'd2);
    conf_mode = 2'b01; conf_base_addr = 8'd100; conf_trans_num = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, 200);
    check_eq("busy_start_count", DDR_W'(got_q.size()), DDR_W'(2));
    check_eq("busy_start_rd_cnt", DDR_W'(rd_cnt), DDR_W'(2));
    if (got_q.size() > 1) check_eq("busy_start_word", got_q[1], splat(32'd50));

    // Reset mid-transfer
    ddr2_if.ddr2_ready = 1'b0;
    do_start(2'b00, 2'd0, 8'd0, 8'd8);
    repeat (5) @(posedge clk);
    #1;
    check_eq("pre_reset_valid", DDR_W'(ddr2_if.ddr2_valid), DDR_W'(1));
    rst_n = 1'b0;
    #1;
    check_eq("mid_reset_valid", DDR_W'(ddr2_if.ddr2_valid), '0);
    check_eq("mid_reset_busy", DDR_W'({busy, done, abuf_rd_en}), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ddr2_if.ddr2_ready = 1'b1;

    // Overflowing group sum
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 16; i++) set_lane(50, g, i, 32'h7FFFFFFF);
    do_start(2'b00, 2'd0, 8'd50, 8'd1);
    wait_done(0, 100);
    check_eq("ovf_count", DDR_W'(got_q.size()), DDR_W'(1));
`ifdef PE2DDR_SAT_EN
    if (got_q.size() > 0) check_eq("ovf_word", got_q[0], splat(32'h7FFFFFFF));
`else
    if (got_q.size() > 0) check_eq("ovf_word", got_q[0], splat(32'hFFFFFFFC));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pe2ddr_pack.md
Name: pe2ddr_pack

Overview:
- Parametrised successor to the accumulator/bias write-back path: drains PE accumulator buffer (abuf, GRP_NUM groups × BATCH results) or bias buffer (bbuf, {data,tail} entries) into DDR_W words on a valid/ready stream.
- Sits between PE result buffers and the DDR write channel (ddr2_*).
- Adds true backpressure handling via an output FIFO with read credits, configurable group reduction/selection, programmable base address and word count, and a done pulse.

Parameters:
- BATCH, 16, results per abuf group entry; DDR_W must equal BATCH*RES_W
- GRP_NUM, 4, abuf groups (power of 2, 1..8)
- RES_W, 32, accumulator result width (two's complement)
- DATA_W, 16, bbuf data field width
- TAIL_W, 16, bbuf tail field width; DATA_W+TAIL_W == RES_W
- DDR_W, 512, output word width
- BUF_DEPTH, 256, abuf/bbuf depth
- ADDR_W, bw(BUF_DEPTH), buffer address width
- OFIFO_DEPTH, 4, output FIFO entries (≥4)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches conf_*; ignored unless IDLE
- done  out  1  one-cycle pulse after last output handshake
- busy  out  1  high from accepted start until done
- conf_mode  in  2  00 abuf group sum; 01 abuf group select; 10 bbuf data pack; 11 bbuf tail pack
- conf_grp_sel  in  bw(GRP_NUM)  group index for mode 01
- conf_base_addr  in  ADDR_W  first buffer address
- conf_trans_num  in  8  number of DDR words to emit; 0 = none
- abuf_rd_addr  out  ADDR_W  abuf read address
- abuf_rd_en  out  1  abuf read strobe; data valid next cycle
- abuf_rd_data  in  GRP_NUM*BATCH*RES_W  group g lane i at [(g*BATCH+i)*RES_W +: RES_W]
- bbuf_rd_addr  out  ADDR_W  bbuf read address
- bbuf_rd_en  out  1  bbuf read strobe; data valid next cycle
- bbuf_rd_data  in  RES_W  {data[DATA_W], tail[TAIL_W]}
- ddr2_data  out  DDR_W  output word
- ddr2_valid  out  1  output valid
- ddr2_ready  in  1  sink ready; transfer when valid&ready

Behaviour:
- Reset (async, rst_n=0): state IDLE; done, busy, ddr2_valid, abuf_rd_en, bbuf_rd_en = 0; addresses = 0; FIFO empty; ddr2_data = 0. Mid-operation reset discards all in-flight data.
- FSM: IDLE → RUN on start (trans_num>0); IDLE → DONE on start with trans_num=0. RUN → DRAIN when last read issued. DRAIN → DONE when FIFO empty, pipeline empty, and last word handshaked. DONE → IDLE next cycle; done=1 only in DONE.
- Read issue rule: in RUN, issue one read per cycle iff (FIFO occupancy + words in flight) < OFIFO_DEPTH. Reads never depend combinationally on ddr2_ready.
- Modes 00/01: one abuf read per output word; address base, base+1, ... Cycle t read, t+1 data, t+2 registered reduction result written into FIFO. Mode 00: lane i = wrapping RES_W sum over all groups. Mode 01: lane i = group conf_grp_sel. Lane i at ddr2_data[i*RES_W +: RES_W].
- Mode 10: DPACK=DDR_W/DATA_W consecutive bbuf reads per word; k-th read's data field at lane k (lane 0 = LSB). Mode 11: same with tail field, TPACK=DDR_W/TAIL_W. Credit counts whole words; word enters FIFO one cycle after its last read's data.
- Address increments per read and wraps BUF_DEPTH-1 → 0.
- FIFO first-word-fall-through: ddr2_valid = !empty; ddr2_data stable while valid&!ready. Push and pop in the same cycle keep occupancy unchanged; full-throughput 1 word/cycle when ready held high (modes 00/01).
- Minimum latency start → first ddr2_valid: 4 cycles (modes 00/01).
- start while busy: ignored, config unchanged.

Optional Feature:
- PE2DDR_SAT_EN: when defined, mode 00 sums use a GRP_NUM-extended internal width and saturate to [-2^(RES_W-1), 2^(RES_W-1)-1]; latency unchanged. When undefined, sums wrap modulo 2^RES_W.

Test Plan:
- Mode 00, trans_num=3, base=10, ready=1, abuf groups each lane = 1,2,3,4 → three words, every lane 10; addresses 10,11,12; done one cycle after third handshake.
- Mode 01, grp_sel=2, lane i of group 2 = i → word lanes 0..15 = 0..15; ready toggled 1/0 each cycle → no duplication/loss, data held during stall.
- Mode 10, trans_num=1, bbuf[k]={k, 16'hFFFF}, k=0..31 → word lanes 0..31 = 0..31; mode 11 same buffer → all lanes 16'hFFFF.
- ready=0 for 20 cycles, mode 00, trans_num=8 → exactly OFIFO_DEPTH reads issued then stall; release → 8 words in order; base=254 wraps to 0.
- trans_num=0 → done at 1 cycle after start, no valid; start during busy ignored; rst_n low mid-transfer → valid=0 immediately, IDLE.
- Mode 00 lanes 32'h7FFFFFFF×4 → 32'hFFFFFFFC without macro; 32'h7FFFFFFF with PE2DDR_SAT_EN.
